// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs decoded MIPS instruction fields (R/I/J) into
// 32-bit words and writes them sequentially into instruction memory from
// BASE_ADDR onward. A session begins with start and ends after the tuple
// flagged last, or when the memory window of DEPTH words is full.
// Optional build macro ENC_CHECKSUM_EN adds a running XOR checksum output
// covering every word written in the session.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; address/count/flags hold
// S_LOAD  | in_ready high, waiting for a field tuple
// S_WRITE | mem_we high for one cycle with the registered word
// S_DONE  | done pulse, then back to idle
module instr_encode_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int BASE_ADDR  = 0,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            fmt,
   input  logic [5:0]            Op,
   input  logic [4:0]            Rs,
   input  logic [4:0]            Rt,
   input  logic [4:0]            Rd,
   input  logic [4:0]            shamt,
   input  logic [5:0]            funct,
   input  logic [15:0]           imm,
   input  logic [25:0]           addr,
   input  logic                  last,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  err_fmt,
`ifdef ENC_CHECKSUM_EN
   output logic                  err_overflow,
   output logic [31:0]           checksum
`else
   output logic                  err_overflow
`endif
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(BASE_ADDR + DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  last_q, last_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  err_fmt_q, err_fmt_d;
   logic                  err_ovf_q, err_ovf_d;
   logic [31:0]           enc_word;
   logic                  accept;
`ifdef ENC_CHECKSUM_EN
   logic [31:0]           cks_q, cks_d;
`endif

   assign accept = (state_q == S_LOAD) && in_valid;

   // Field packing; fmt=3 yields a NOP word and is flagged separately.
   always_comb begin
      enc_word = 32'h0000_0000;
      case (fmt)
         2'd0:    enc_word = {Op, Rs, Rt, Rd, shamt, funct};
         2'd1:    enc_word = {Op, Rs, Rt, imm};
         2'd2:    enc_word = {Op, addr};
         default: enc_word = 32'h0000_0000;
      endcase
   end

   // Next-state and datapath update for the load sequencer.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      last_d    = last_q;
      count_d   = count_q;
      err_fmt_d = err_fmt_q;
      err_ovf_d = err_ovf_q;
`ifdef ENC_CHECKSUM_EN
      cks_d     = cks_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d    = ADDR_FIRST;
               count_d   = '0;
               err_fmt_d = 1'b0;
               err_ovf_d = 1'b0;
`ifdef ENC_CHECKSUM_EN
               cks_d     = 32'h0000_0000;
`endif
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            if (accept) begin
               wdata_d = enc_word;
               last_d  = last;
               if (fmt == 2'd3) begin
                  err_fmt_d = 1'b1;
               end
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            count_d = count_q + COUNT_ONE;
`ifdef ENC_CHECKSUM_EN
            cks_d   = cks_q ^ wdata_q;
`endif
            if (last_q) begin
               state_d = S_DONE;
            end else if (addr_q == ADDR_LAST) begin
               // Window full before the program ended: stop rather than wrap.
               err_ovf_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               addr_d  = addr_q + ADDR_ONE;
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; async reset so mem_we drops immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         addr_q    <= ADDR_FIRST;
         wdata_q   <= 32'h0000_0000;
         last_q    <= 1'b0;
         count_q   <= '0;
         err_fmt_q <= 1'b0;
         err_ovf_q <= 1'b0;
`ifdef ENC_CHECKSUM_EN
         cks_q     <= 32'h0000_0000;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         last_q    <= last_d;
         count_q   <= count_d;
         err_fmt_q <= err_fmt_d;
         err_ovf_q <= err_ovf_d;
`ifdef ENC_CHECKSUM_EN
         cks_q     <= cks_d;
`endif
      end
   end

   assign in_ready     = (state_q == S_LOAD);
   assign mem_we       = (state_q == S_WRITE);
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign count        = count_q;
   assign err_fmt      = err_fmt_q;
   assign err_overflow = err_ovf_q;
`ifdef ENC_CHECKSUM_EN
   assign checksum     = cks_q;
`endif

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader with a 4-word memory window so the
// overflow stop is reachable. Writes are checked by a scoreboard queue.
module tb_instr_encode_loader;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    fmt_s = '0;
   logic [5:0]    op_s = '0;
   logic [4:0]    rs_s = '0, rt_s = '0, rd_s = '0, sh_s = '0;
   logic [5:0]    fn_s = '0;
   logic [15:0]   imm_s = '0;
   logic [25:0]   ad_s = '0;
   logic          last_s = 1'b0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          busy, done, err_fmt, err_overflow;
   logic [AW:0]   count;
`ifdef ENC_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   instr_encode_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt_s), .Op(op_s), .Rs(rs_s), .Rt(rt_s), .Rd(rd_s),
      .shamt(sh_s), .funct(fn_s), .imm(imm_s), .addr(ad_s), .last(last_s),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .count(count), .err_fmt(err_fmt),
`ifdef ENC_CHECKSUM_EN
      .err_overflow(err_overflow), .checksum(checksum)
`else
      .err_overflow(err_overflow)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  fmt;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] ad;
      logic [31:0] exp;
      logic        exp_ef;
   } vec_t;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   vec_t          tbl[6];
   vec_t          seq[3];
   wr_t           sb[$];
   wr_t           sb_e;
   logic [AW-1:0] exp_addr = '0;
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (reset_n && mem_we) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d data 0x%08h", mem_addr, mem_wdata);
         end else begin
            sb_e = sb.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(sb_e.a));
            chk("wr_data", mem_wdata, sb_e.d);
         end
      end
   end

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_addr = '0;
   endtask

   task automatic drive(input vec_t v, input logic l);
      fmt_s = v.fmt; op_s = v.op; rs_s = v.rs; rt_s = v.rt; rd_s = v.rd;
      sh_s = v.sh; fn_s = v.fn; imm_s = v.imm; ad_s = v.ad; last_s = l;
      in_valid = 1'b1;
   endtask

   // Offers one tuple, expects it written at the next expected address;
   // returns at the falling edge inside the WRITE cycle.
   task automatic send(input vec_t v, input logic l);
      int n;
      drive(v, l);
      sb.push_back({exp_addr, v.exp});
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("ready_low_write", 32'(in_ready), 32'd0);
      chk("we_in_write", 32'(mem_we), 32'd1);
      exp_addr = exp_addr + AW'(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hBEEF, 26'h3ABCDEF, 32'h0022_1820, 1'b0};
      tbl[1] = '{2'd0, 6'h00, 5'd0, 5'd9, 5'd10, 5'd4, 6'h00, 16'h1234, 26'h1555555, 32'h0009_5100, 1'b0};
      tbl[2] = '{2'd1, 6'h04, 5'd3, 5'd5, 5'd31, 5'd31, 6'h3F, 16'hFFFE, 26'h2AAAAAA, 32'h1065_FFFE, 1'b0};
      tbl[3] = '{2'd2, 6'h03, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h0FFF_FFFF, 1'b0};
      tbl[4] = '{2'd3, 6'h23, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h0001, 26'h0000001, 32'h0000_0000, 1'b1};
      tbl[5] = '{2'd1, 6'h08, 5'd1, 5'd2, 5'd7, 5'd7, 6'h07, 16'h0005, 26'h0000000, 32'h2022_0005, 1'b0};
      seq[0] = '{2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0, 32'h2022_0005, 1'b0};
      seq[1] = '{2'd1, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0, 32'h8FA8_0004, 1'b0};
      seq[2] = '{2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h10, 32'h0800_0010, 1'b0};

      // Reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_errs", {30'd0, err_fmt, err_overflow}, 32'd0);
      reset_n = 1'b1;

      // Single-tuple sessions from the vector table
      for (int i = 0; i < 6; i++) begin
         do_start();
         chk("start_busy", 32'(busy), 32'd1);
         chk("start_count", 32'(count), 32'd0);
         chk("start_err_fmt", 32'(err_fmt), 32'd0);
         chk("start_err_ovf", 32'(err_overflow), 32'd0);
         send(tbl[i], 1'b1);
         @(negedge clk);
         chk("tbl_done", 32'(done), 32'd1);
         chk("tbl_count", 32'(count), 32'd1);
         @(negedge clk);
         chk("tbl_done_clr", 32'(done), 32'd0);
         chk("tbl_idle", 32'(busy), 32'd0);
         chk("tbl_addr_hold", 32'(mem_addr), 32'd0);
         chk("tbl_err_fmt", 32'(err_fmt), 32'(tbl[i].exp_ef));
      end

      // Three back-to-back tuples
      do_start();
      send(seq[0], 1'b0);
      send(seq[1], 1'b0);
      send(seq[2], 1'b1);
      @(negedge clk);
      chk("seq_done", 32'(done), 32'd1);
      chk("seq_count", 32'(count), 32'd3);
      chk("seq_addr", 32'(mem_addr), 32'd2);
`ifdef ENC_CHECKSUM_EN
      chk("seq_checksum", checksum, 32'hA78A_0011);
`endif
      @(negedge clk);
      chk("seq_idle", 32'(busy), 32'd0);

      // Stall in LOAD with start pulsed mid-session
      do_start();
      send(tbl[0], 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         start = (k == 2);
         chk("stall_ready", 32'(in_ready), 32'd1);
      end
      start = 1'b0;
      chk("stall_count", 32'(count), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'd1);
      send(tbl[2], 1'b1);
      @(negedge clk);
      chk("stall_done", 32'(done), 32'd1);
      chk("stall_count2", 32'(count), 32'd2);
      @(negedge clk);

      // Overflow: four tuples fill the window, fifth is never accepted
      do_start();
      for (int k = 0; k < 4; k++) send(tbl[k], 1'b0);
      drive(tbl[5], 1'b1);
      @(negedge clk);
      chk("ovf_done", 32'(done), 32'd1);
      chk("ovf_flag", 32'(err_overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd4);
      chk("ovf_addr", 32'(mem_addr), 32'd3);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("ovf_no_ready", 32'(in_ready), 32'd0);
      end
      chk("ovf_sticky", 32'(err_overflow), 32'd1);
      in_valid = 1'b0;

      // Reset asserted during a WRITE cycle
      do_start();
      send(tbl[0], 1'b0);
      send(tbl[1], 1'b0);
      chk("pre_rst_count", 32'(count), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_we_drop", 32'(mem_we), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_count", 32'(count), 32'd0);
      chk("post_rst_addr", 32'(mem_addr), 32'd0);
      chk("post_rst_ready", 32'(in_ready), 32'd0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
